// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: opcodes, instruction field positions and
// IF/ID stage state encoding.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_LW    = 6'h23;

  localparam int unsigned OP_MSB = 31;
  localparam int unsigned OP_LSB = 26;
  localparam int unsigned RS_MSB = 25;
  localparam int unsigned RS_LSB = 21;
  localparam int unsigned RT_MSB = 20;
  localparam int unsigned RT_LSB = 16;
  localparam int unsigned RD_MSB = 15;
  localparam int unsigned RD_LSB = 11;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } ifid_state_e;

  // Instructions that read rt as a source operand.
  function automatic logic uses_rt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection between the IF/ID instruction and an ID/EX load.
module hazard_detect
  import mips_pkg::*;
(
  input  logic [31:0] id_inst,
  input  logic        id_valid,
  input  logic        idex_mem_read,
  input  logic [4:0]  idex_rt,
  output logic        load_use
);

  logic [5:0] op;
  logic [4:0] rs;
  logic [4:0] rt;
  logic       unused_imm;

  assign op         = id_inst[OP_MSB:OP_LSB];
  assign rs         = id_inst[RS_MSB:RS_LSB];
  assign rt         = id_inst[RT_MSB:RT_LSB];
  assign unused_imm = ^id_inst[15:0];

  always_comb begin
    load_use = id_valid && idex_mem_read && (idex_rt != 5'd0) &&
               ((idex_rt == rs) || (uses_rt(op) && (idex_rt == rt)));
  end

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with load-use stall, bubble insertion and flush.
// Optional performance counters enabled by defining IFID_PERF_CNT_EN.
module if_id_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] if_inst,
  input  logic [31:0] if_pc4,
  input  logic        flush,
  input  logic        ext_stall,
  input  logic        idex_mem_read,
  input  logic [4:0]  idex_rt,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc4,
  output logic        id_valid,
  output logic        pc_write,
`ifdef IFID_PERF_CNT_EN
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count,
`endif
  output logic        id_bubble
);

  ifid_state_e state_q;
  logic [31:0] inst_q;
  logic [31:0] pc4_q;
  logic        load_use;
  logic        hold;

  // The slot is live whenever the FSM is not EMPTY; no separate valid flop.
  assign id_valid = (state_q != EMPTY);
  assign id_inst  = inst_q;
  assign id_pc4   = pc4_q;

  hazard_detect u_hazard_detect (
    .id_inst       (inst_q),
    .id_valid      (id_valid),
    .idex_mem_read (idex_mem_read),
    .idex_rt       (idex_rt),
    .load_use      (load_use)
  );

  assign hold      = load_use | ext_stall;
  assign pc_write  = ~reset | flush | ~hold;
  assign id_bubble = reset & ~flush & load_use;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= EMPTY;
      inst_q  <= NOP_WORD;
      pc4_q   <= '0;
    end else if (flush) begin
      state_q <= EMPTY;
      inst_q  <= NOP_WORD;
    end else if (hold) begin
      // An empty slot under ext_stall has nothing to hold; it stays invalid.
      state_q <= (state_q == EMPTY) ? EMPTY : STALL;
    end else begin
      state_q <= RUN;
      inst_q  <= if_inst;
      pc4_q   <= if_pc4;
    end
  end

`ifdef IFID_PERF_CNT_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] flush_count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      if (hold && !flush) stall_cycles_q <= stall_cycles_q + 32'd1;
      if (flush && id_valid) flush_count_q <= flush_count_q + 32'd1;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`endif

endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- IF/ID pipeline boundary of the 32-bit MIPS core. Sits directly downstream of Fetch and consumes its instruction word and PC+4.
- Holds the instruction for the Decode stage and detects load-use hazards against the ID/EX instruction.
- Drives PCWrite back to Fetch, inserts bubbles, and squashes the held instruction on redirects (jump or taken branch).

Parameters:
- NOP_WORD, 32'h0000_0000, instruction word presented on id_inst when the slot is invalid.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_inst  in  32  instruction from Fetch (inst).
- if_pc4  in  32  PC+4 from Fetch (ifOut).
- flush  in  1  redirect from Jump/branch resolution; squash the IF/ID slot.
- ext_stall  in  1  external hold request (e.g. memory not ready).
- idex_mem_read  in  1  instruction in ID/EX is a load.
- idex_rt  in  5  destination register of the ID/EX load.
- id_inst  out  32  held instruction; NOP_WORD when invalid.
- id_pc4  out  32  held PC+4.
- id_valid  out  1  slot holds a live instruction.
- pc_write  out  1  to Fetch PCWrite; 0 freezes the PC.
- id_bubble  out  1  ID/EX must load a bubble (control bits zeroed) this cycle.

Behaviour:
- Reset (reset=0, async): id_inst=NOP_WORD, id_pc4=0, id_valid=0, state=EMPTY. While reset is held: pc_write=1, id_bubble=0.
- States:
  - EMPTY: no valid instruction.
  - RUN: valid instruction held.
  - STALL: hazard hold in progress.
- Hazard (combinational): load_use = id_valid & idex_mem_read & (idex_rt != 0) & ((idex_rt == rs) | (uses_rt & idex_rt == rt)).
  - rs = id_inst[25:21], rt = id_inst[20:16].
  - uses_rt is true for opcode 6'h00, 6'h04, 6'h05, 6'h2B.
- hold = load_use | ext_stall.
- Priority per edge: reset > flush > hold > load.
  - flush: id_valid<=0, id_inst<=NOP_WORD, id_pc4 unchanged, next state EMPTY. pc_write=1 regardless of hold.
  - hold (no flush): registers unchanged, pc_write=0. id_bubble=load_use. Next state STALL.
  - load: id_inst<=if_inst, id_pc4<=if_pc4, id_valid<=1, next state RUN. pc_write=1, id_bubble=0.
- STALL exit: on the first cycle hold is low, the stage loads normally and goes to RUN.
  - A load-use stall lasts exactly 1 cycle, because the bubble removes the load from ID/EX.
  - ext_stall may extend a stall indefinitely.
- Latency: one cycle from if_inst to id_inst.
- EMPTY: load_use is forced 0 (id_valid=0). ext_stall still freezes the PC.
- pc_write and id_bubble are combinational from current state and inputs, with no registered lag.
- Reset asserted mid-stall: immediate clear to EMPTY. The first edge after release loads if_inst.

Optional Feature:
- Macro IFID_PERF_CNT_EN.
- Defined: adds outputs stall_cycles[31:0] and flush_count[31:0], both reset to 0.
  - stall_cycles increments on each edge where hold & ~flush.
  - flush_count increments on each edge where flush is 1 and id_valid was 1.
  - Both wrap at 2^32 without saturation.
- Undefined: neither port nor counter exists. Behaviour is otherwise identical.

Decomposition:
- Shared package mips_pkg holds:
  - opcode constants OP_RTYPE=6'h00, OP_BEQ=6'h04, OP_BNE=6'h05, OP_SW=6'h2B, OP_LW=6'h23;
  - field-slice localparams for rs/rt/rd;
  - the state encoding EMPTY=2'd0, RUN=2'd1, STALL=2'd2.
- One sub-module is natural: hazard_detect. It is purely combinational: inputs id_inst, id_valid, idex_mem_read, idex_rt; output load_use. It is reused by later forwarding work.

Test Plan:
- Reset then stream: reset low 3 cycles, release, feed if_inst=32'h2008_0005 (addi $8,$0,5) with if_pc4=32'h4 -> after 1 edge id_inst=32'h2008_0005, id_pc4=4, id_valid=1, pc_write=1.
- Load-use stall: id_inst=32'h0109_5020 (add $10,$8,$9), idex_mem_read=1, idex_rt=8 -> pc_write=0 and id_bubble=1 for exactly 1 cycle, id_inst held. Next cycle, with idex_mem_read=0, the stage loads the new if_inst.
- No hazard on $0 or on an unused rt: idex_rt=0 -> no stall. id_inst=32'h8D09_0000 (lw $9,0($8)) with idex_rt=9 -> no stall, because lw does not use rt.
- Flush beats stall: load_use and flush=1 in the same cycle -> pc_write=1; next edge id_valid=0, id_inst=NOP_WORD, state EMPTY.
- ext_stall hold: ext_stall=1 for 4 cycles -> id_inst and id_pc4 stable, pc_write=0 all 4 cycles, id_bubble=0. With IFID_PERF_CNT_EN defined, stall_cycles=4.
- Async reset mid-stall: drop reset between edges during STALL -> outputs clear immediately without waiting for clk.
